// File: rtl/mem_access_ctrl.sv
// Data-RAM initiator: turns one MEM-stage load/store into a registered byte-lane RAM access,
// extracts/extends load data, stalls while busy and flags misaligned or out-of-range addresses.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_o,
  output logic [ADDR_W-1:0] badaddr_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_vldbyte_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  localparam logic [2:0] OpLb  = 3'd0;
  localparam logic [2:0] OpLbu = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLw  = 3'd4;
  localparam logic [2:0] OpSb  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSw  = 3'd7;

  localparam logic [ADDR_W-1:0] MemWordsW = ADDR_W'(MEM_WORDS);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic              ce_q, we_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [3:0]        vld_q, vld_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] badaddr_q;

  logic is_store, is_half, is_word, misaligned, out_of_range, fault, accept, load_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  assign is_store     = (op_i == OpSb) || (op_i == OpSh) || (op_i == OpSw);
  assign is_half      = (op_i == OpLh) || (op_i == OpLhu) || (op_i == OpSh);
  assign is_word      = (op_i == OpLw) || (op_i == OpSw);
  assign misaligned   = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
  assign out_of_range = (addr_i >> 2) >= MemWordsW;
  assign fault        = misaligned || out_of_range;
  assign accept       = (state_q == StIdle) && req_i;
  assign load_q       = op_q < OpSb;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_i) state_d = fault ? StErr : StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in [31:24].
  always_comb begin
    vld_d  = 4'b0000;
    wdat_d = 32'h0;
    unique case (op_i)
      OpSb: begin
        vld_d  = 4'b1000 >> addr_i[1:0];
        wdat_d = {4{wdata_i[7:0]}};
      end
      OpSh: begin
        vld_d  = addr_i[1] ? 4'b0011 : 4'b1100;
        wdat_d = {2{wdata_i[15:0]}};
      end
      OpSw: begin
        vld_d  = 4'b1111;
        wdat_d = wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (off_q)
      2'd0:    byte_sel = ram_data_i[31:24];
      2'd1:    byte_sel = ram_data_i[23:16];
      2'd2:    byte_sel = ram_data_i[15:8];
      default: byte_sel = ram_data_i[7:0];
    endcase
    half_sel = off_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    unique case (op_q)
      OpLb:    ext = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   ext = {24'h0, byte_sel};
      OpLh:    ext = {{16{half_sel[15]}}, half_sel};
      OpLhu:   ext = {16'h0, half_sel};
      default: ext = ram_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpLb;
      off_q     <= 2'b00;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      raddr_q   <= '0;
      vld_q     <= 4'b0000;
      wdat_q    <= 32'h0;
      rdata_q   <= 32'h0;
      badaddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !fault) begin
        op_q    <= op_i;
        off_q   <= addr_i[1:0];
        ce_q    <= 1'b1;
        we_q    <= is_store;
        raddr_q <= {addr_i[ADDR_W-1:2], 2'b00};
        vld_q   <= vld_d;
        wdat_q  <= wdat_d;
      end else if (state_q == StAccess) begin
        ce_q    <= 1'b0;
        we_q    <= 1'b0;
        raddr_q <= '0;
        vld_q   <= 4'b0000;
        wdat_q  <= 32'h0;
        if (load_q) rdata_q <= ext;
      end
      if (accept && fault) badaddr_q <= addr_i;
    end
  end

  // Gated by rst_n so a held request cannot raise stall while in reset.
  assign stall_o       = rst_n && (accept || (state_q == StAccess));
  assign done_o        = state_q == StDone;
  assign exc_o         = state_q == StErr;
  assign rdata_o       = rdata_q;
  assign badaddr_o     = badaddr_q;
  assign ram_ce_o      = ce_q;
  assign ram_we_o      = we_q;
  assign ram_addr_o    = raddr_q;
  assign ram_vldbyte_o = vld_q;
  assign ram_data_o    = wdat_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized ops against a byte-array model,
// and a mid-access reset sequence.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_WORDS = 63;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3;
  localparam logic [2:0] LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic              clk, rst_n, req_i;
  logic [2:0]        op_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              stall_o, done_o, exc_o, ram_ce_o, ram_we_o;
  logic [31:0]       rdata_o, ram_data_o, ram_data_i;
  logic [ADDR_W-1:0] badaddr_o, ram_addr_o;
  logic [3:0]        ram_vldbyte_o;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .exc_o(exc_o),
    .badaddr_o(badaddr_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_vldbyte_o(ram_vldbyte_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment: combinational read, byte-lane write on posedge.
  logic [31:0]       ram [MEM_WORDS] = '{default: '0};
  logic [ADDR_W-1:0] ram_idx;
  assign ram_idx = ram_addr_o >> 2;
  always_comb ram_data_i = (ram_idx < MEM_WORDS) ? ram[ram_idx[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o && ram_idx < MEM_WORDS)
      for (int l = 0; l < 4; l++)
        if (ram_vldbyte_o[l]) ram[ram_idx[5:0]][8*l +: 8] <= ram_data_o[8*l +: 8];
  end

  int acc_cnt = 0;
  always @(posedge clk) if (rst_n && ram_ce_o) acc_cnt <= acc_cnt + 1;

  // Reference model: flat big-endian byte memory.
  logic [7:0]  ref_b [4*MEM_WORDS] = '{default: '0};
  logic [31:0] last_rd  = 32'h0;
  logic [31:0] last_bad = 32'h0;
  int exp_acc = 0;
  int checks = 0, failures = 0;

  function automatic int size_of(input logic [2:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_st(input logic [2:0] op);
    return op >= SB;
  endfunction

  function automatic bit ref_fault(input logic [2:0] op, input logic [31:0] addr);
    longint unsigned a = longint'(addr);
    return (a % size_of(op) != 0) || (a / 4 >= MEM_WORDS);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v = 32'h0;
    int sz = size_of(op);
    for (int i = 0; i < sz; i++) v = (v << 8) | {24'h0, ref_b[int'(addr) + i]};
    if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
    if (op == LH && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [3:0] ref_vld(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] v = 4'b0000;
    if (is_st(op))
      for (int i = 0; i < size_of(op); i++) v[3 - (int'(addr[1:0]) + i)] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] w);
    if (op == SB) return {4{w[7:0]}};
    if (op == SH) return {2{w[15:0]}};
    if (op == SW) return w;
    return 32'h0;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
    int sz = size_of(op);
    for (int i = 0; i < sz; i++) ref_b[int'(addr) + i] = w[8*(sz-1-i) +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_stall"}, stall_o, 1'b0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_exc"}, exc_o, 1'b0);
    chk1({tag, "_ce"}, ram_ce_o, 1'b0);
    chk1({tag, "_we"}, ram_we_o, 1'b0);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_badaddr"}, badaddr_o, 32'h0);
    check({tag, "_raddr"}, ram_addr_o, 32'h0);
    check({tag, "_vld"}, {28'h0, ram_vldbyte_o}, 32'h0);
    check({tag, "_rwdata"}, ram_data_o, 32'h0);
  endtask

  // One request held through DONE/ERR; returns just after the posedge back into IDLE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w,
                       input logic exp_fault, input logic [3:0] exp_vld,
                       input logic [31:0] exp_rd);
    logic [31:0] rd_exp;
    rd_exp  = is_st(op) ? last_rd : exp_rd;
    op_i    = op;
    addr_i  = addr;
    wdata_i = w;
    req_i   = 1'b1;
    @(negedge clk);
    chk1("c0_stall", stall_o, 1'b1);
    chk1("c0_ce", ram_ce_o, 1'b0);
    step();
    @(negedge clk);
    if (exp_fault) begin
      chk1("err_exc", exc_o, 1'b1);
      check("err_badaddr", badaddr_o, addr);
      chk1("err_ce", ram_ce_o, 1'b0);
      chk1("err_done", done_o, 1'b0);
      chk1("err_stall", stall_o, 1'b0);
      check("err_rdata", rdata_o, last_rd);
      last_bad = addr;
      step();
    end else begin
      chk1("acc_ce", ram_ce_o, 1'b1);
      chk1("acc_we", ram_we_o, is_st(op));
      check("acc_addr", ram_addr_o, {addr[31:2], 2'b00});
      check("acc_vld", {28'h0, ram_vldbyte_o}, {28'h0, exp_vld});
      check("acc_wdata", ram_data_o, ref_wdata(op, w));
      chk1("acc_stall", stall_o, 1'b1);
      chk1("acc_done", done_o, 1'b0);
      chk1("acc_exc", exc_o, 1'b0);
      step();
      @(negedge clk);
      chk1("done_done", done_o, 1'b1);
      chk1("done_stall", stall_o, 1'b0);
      chk1("done_ce", ram_ce_o, 1'b0);
      chk1("done_exc", exc_o, 1'b0);
      check("done_rdata", rdata_o, rd_exp);
      if (is_st(op)) ref_store(op, addr, w);
      last_rd = rd_exp;
      exp_acc++;
      step();
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [3:0]  vld;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, w;
    logic        f;

    tbl[0]  = '{SW,  32'h08, 32'h1122_3344, 1'b0, 4'b1111, 32'h0};
    tbl[1]  = '{LW,  32'h08, 32'h0,         1'b0, 4'b0000, 32'h1122_3344};
    tbl[2]  = '{LB,  32'h09, 32'h0,         1'b0, 4'b0000, 32'h0000_0022};
    tbl[3]  = '{LBU, 32'h09, 32'h0,         1'b0, 4'b0000, 32'h0000_0022};
    tbl[4]  = '{SB,  32'h09, 32'h0000_0080, 1'b0, 4'b0100, 32'h0};
    tbl[5]  = '{LB,  32'h09, 32'h0,         1'b0, 4'b0000, 32'hFFFF_FF80};
    tbl[6]  = '{LBU, 32'h09, 32'h0,         1'b0, 4'b0000, 32'h0000_0080};
    tbl[7]  = '{SH,  32'h0A, 32'h0000_BEEF, 1'b0, 4'b0011, 32'h0};
    tbl[8]  = '{LW,  32'h08, 32'h0,         1'b0, 4'b0000, 32'h1180_BEEF};
    tbl[9]  = '{LH,  32'h0A, 32'h0,         1'b0, 4'b0000, 32'hFFFF_BEEF};
    tbl[10] = '{LHU, 32'h0A, 32'h0,         1'b0, 4'b0000, 32'h0000_BEEF};
    tbl[11] = '{LB,  32'h0B, 32'h0,         1'b0, 4'b0000, 32'hFFFF_FFEF};
    tbl[12] = '{LW,  32'h06, 32'h0,         1'b1, 4'b0000, 32'h0};
    tbl[13] = '{LH,  32'h03, 32'h0,         1'b1, 4'b0000, 32'h0};
    tbl[14] = '{LW,  32'hFC, 32'h0,         1'b1, 4'b0000, 32'h0};
    tbl[15] = '{SW,  32'hF8, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0};
    tbl[16] = '{LW,  32'hF8, 32'h0,         1'b0, 4'b0000, 32'hCAFE_F00D};

    rst_n = 1'b0; req_i = 1'b0; op_i = 3'd0; addr_i = '0; wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++)
      do_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].fault, tbl[i].vld, tbl[i].rd);
    req_i = 1'b0;
    @(negedge clk);
    chk1("idle_stall", stall_o, 1'b0);
    check("idle_badaddr", badaddr_o, 32'hFC);
    check("idle_rdata", rdata_o, 32'hCAFE_F00D);
    step();

    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 4 * MEM_WORDS + 7);
      w  = $urandom;
      if (size_of(op) > 1 && $urandom_range(0, 3) != 0) a = a & ~32'(size_of(op) - 1);
      f = ref_fault(op, a);
      do_op(op, a, w, f, f ? 4'b0000 : ref_vld(op, a),
            (!f && !is_st(op)) ? ref_load(op, a) : last_rd);
      if ($urandom_range(0, 3) == 0) begin
        req_i = 1'b0;
        @(negedge clk);
        chk1("gap_stall", stall_o, 1'b0);
        check("gap_badaddr", badaddr_o, last_bad);
        step();
      end
    end

    // Reset in the middle of a store's ACCESS cycle.
    do_op(SW, 32'h10, 32'h5A5A_0101, 1'b0, 4'b1111, 32'h0);
    op_i = SW; addr_i = 32'h10; wdata_i = 32'hDEAD_BEEF; req_i = 1'b1;
    step();
    @(negedge clk);
    chk1("mid_ce", ram_ce_o, 1'b1);
    #2;
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    check_zero("midrst");
    step();
    check("midrst_ram", ram[4], 32'h5A5A_0101);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd  = 32'h0;
    last_bad = 32'h0;
    step();
    do_op(LW, 32'h10, 32'h0, 1'b0, 4'b0000, ref_load(LW, 32'h10));
    req_i = 1'b0;
    step();

    check("acc_count", 32'(acc_cnt), 32'(exp_acc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
